// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: E-stage request/response bundle between the pipeline and the MDU.
// The master side (pipeline) drives the op request and reads busy/occupied/HI/LO.
interface mdu_hilo_if;
   logic        start;
   logic [3:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        occupied;
   logic [31:0] HI;
   logic [31:0] LO;

   modport slave (
      input  start, op, A, B,
      output busy, occupied, HI, LO
   );

   modport master (
      output start, op, A, B,
      input  busy, occupied, HI, LO
   );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit holding the HI/LO registers.
// The result is computed when the op is accepted and parked in a pending register;
// it only reaches HI/LO when the busy down-counter expires, so the pipeline sees
// exactly the advertised latency. Define MDU_MADD_EN to implement MADD/MADDU/MSUB/MSUBU
// (ops 6-9); otherwise those codes are no-ops and no accumulate adder exists.
// MULT_CYCLES and DIV_CYCLES must both be at least 1.
module mdu_hilo #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic        clk,
   input logic        reset_n,
   mdu_hilo_if.slave  bus
);

   localparam logic [3:0] OpMult  = 4'd0;
   localparam logic [3:0] OpMultu = 4'd1;
   localparam logic [3:0] OpDiv   = 4'd2;
   localparam logic [3:0] OpDivu  = 4'd3;
   localparam logic [3:0] OpMthi  = 4'd4;
   localparam logic [3:0] OpMtlo  = 4'd5;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OpMadd  = 4'd6;
   localparam logic [3:0] OpMaddu = 4'd7;
   localparam logic [3:0] OpMsub  = 4'd8;
   localparam logic [3:0] OpMsubu = 4'd9;
`endif

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic              busy_q;
   logic              div0_q;
   logic [31:0]       hi_q;
   logic [31:0]       lo_q;
   logic [63:0]       pend_q;

   // Datapath terms
   logic [63:0]       a_sx, b_sx;
   logic [63:0]       prod_s, prod_u;
   logic              b_nz;
   logic [31:0]       a_mag, b_mag, div_s, div_u;
   logic [31:0]       q_mag, r_mag, q_s, r_s, q_u, r_u;

   // Decoded request
   logic [63:0]       res;
   logic              load;
   logic              div0;
   logic              wr_hi;
   logic              wr_lo;
   logic [CntW-1:0]   cycles;

   // Multiply and divide results for the operands presented this cycle.
   always_comb begin
      a_sx   = {{32{bus.A[31]}}, bus.A};
      b_sx   = {{32{bus.B[31]}}, bus.B};
      // Low 64 bits of the sign-extended product equal the signed 32x32 product.
      prod_s = a_sx * b_sx;
      prod_u = {32'd0, bus.A} * {32'd0, bus.B};

      b_nz   = (bus.B != 32'd0);
      // Magnitudes: 0x80000000 maps to itself, which is correct as an unsigned 2^31.
      a_mag  = bus.A[31] ? (32'd0 - bus.A) : bus.A;
      b_mag  = bus.B[31] ? (32'd0 - bus.B) : bus.B;
      // A zero divisor is swapped for 1 to keep the divider defined; the result is dropped.
      div_s  = b_nz ? b_mag : 32'd1;
      div_u  = b_nz ? bus.B : 32'd1;
      q_mag  = a_mag / div_s;
      r_mag  = a_mag % div_s;
      // Truncate toward zero; remainder follows the dividend. 0x80000000/-1 lands on
      // q_mag = 2^31 with a positive sign, giving LO = 0x80000000, HI = 0.
      q_s    = (bus.A[31] ^ bus.B[31]) ? (32'd0 - q_mag) : q_mag;
      r_s    = bus.A[31] ? (32'd0 - r_mag) : r_mag;
      q_u    = bus.A / div_u;
      r_u    = bus.A % div_u;
   end

   // Op decode: what the accepted op would do if started this cycle.
   always_comb begin
      res    = 64'd0;
      load   = 1'b0;
      div0   = 1'b0;
      wr_hi  = 1'b0;
      wr_lo  = 1'b0;
      cycles = '0;
      case (bus.op)
         OpMult: begin
            res    = prod_s;
            load   = 1'b1;
            cycles = CntW'(MULT_CYCLES);
         end
         OpMultu: begin
            res    = prod_u;
            load   = 1'b1;
            cycles = CntW'(MULT_CYCLES);
         end
         OpDiv: begin
            res    = {r_s, q_s};
            load   = 1'b1;
            div0   = ~b_nz;
            cycles = CntW'(DIV_CYCLES);
         end
         OpDivu: begin
            res    = {r_u, q_u};
            load   = 1'b1;
            div0   = ~b_nz;
            cycles = CntW'(DIV_CYCLES);
         end
         OpMthi: wr_hi = 1'b1;
         OpMtlo: wr_lo = 1'b1;
`ifdef MDU_MADD_EN
         // Accumulate base is HI/LO as they stand at the start edge.
         OpMadd: begin
            res    = {hi_q, lo_q} + prod_s;
            load   = 1'b1;
            cycles = CntW'(MULT_CYCLES);
         end
         OpMaddu: begin
            res    = {hi_q, lo_q} + prod_u;
            load   = 1'b1;
            cycles = CntW'(MULT_CYCLES);
         end
         OpMsub: begin
            res    = {hi_q, lo_q} - prod_s;
            load   = 1'b1;
            cycles = CntW'(MULT_CYCLES);
         end
         OpMsubu: begin
            res    = {hi_q, lo_q} - prod_u;
            load   = 1'b1;
            cycles = CntW'(MULT_CYCLES);
         end
`endif
         default: ;
      endcase
   end

   // Control FSM with registered busy; owns HI/LO, pending result and the down-counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         div0_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         pend_q  <= 64'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  if (load) begin
                     pend_q  <= res;
                     div0_q  <= div0;
                     cnt_q   <= cycles;
                     busy_q  <= 1'b1;
                     state_q <= StRun;
                  end else begin
                     if (wr_hi) hi_q <= bus.A;
                     if (wr_lo) lo_q <= bus.A;
                  end
               end
            end
            StRun: begin
               // Any start seen here, including MTHI/MTLO, is deliberately dropped.
               if (cnt_q == CntW'(1)) begin
                  if (!div0_q) begin
                     hi_q <= pend_q[63:32];
                     lo_q <= pend_q[31:0];
                  end
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.occupied = bus.start | busy_q;
   assign bus.HI       = hi_q;
   assign bus.LO       = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed vectors; multi-cycle results go through an expected-value
// queue that a negedge monitor pops whenever busy falls.
module tb_mdu_hilo;

   localparam int unsigned MultN = 5;
   localparam int unsigned DivN  = 10;

   localparam logic [3:0] OpMult  = 4'd0;
   localparam logic [3:0] OpMultu = 4'd1;
   localparam logic [3:0] OpDiv   = 4'd2;
   localparam logic [3:0] OpDivu  = 4'd3;
   localparam logic [3:0] OpMthi  = 4'd4;
   localparam logic [3:0] OpMtlo  = 4'd5;
   localparam logic [3:0] OpMaddu = 4'd7;
   localparam logic [3:0] OpRsvd  = 4'd15;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   logic clk;
   logic reset_n;
   int   n_tests;
   int   n_fail;
   exp_t exp_q[$];

   mdu_hilo_if bus ();

   mdu_hilo #(
      .MULT_CYCLES (MultN),
      .DIV_CYCLES  (DivN)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo,
                       input int cycles);
      exp_t e;
      e.name   = name;
      e.hi     = hi;
      e.lo     = lo;
      e.cycles = cycles;
      exp_q.push_back(e);
   endtask

   // Start is sampled at the posedge after drive(); release() leaves us just past t0.
   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
   endtask

   task automatic release_start();
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      drive(op, a, b);
      release_start();
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (bus.busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (bus.busy) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, k);
      end
      @(negedge clk);
   endtask

   // Monitor: count busy cycles, and on each busy fall pop and compare the commit.
   logic prev_busy;
   int   busy_cnt;
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         prev_busy = 1'b0;
         busy_cnt  = 0;
      end else begin
         if (bus.busy) begin
            busy_cnt = prev_busy ? busy_cnt + 1 : 1;
         end else if (prev_busy) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_commit: HI=0x%08h LO=0x%08h, expected no commit",
                        bus.HI, bus.LO);
            end else begin
               e = exp_q.pop_front();
               chk({e.name, "_hi"}, bus.HI, e.hi);
               chk({e.name, "_lo"}, bus.LO, e.lo);
               chk({e.name, "_busy_cycles"}, busy_cnt, e.cycles);
            end
         end
         prev_busy = bus.busy;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic saw_busy;
      n_tests   = 0;
      n_fail    = 0;
      reset_n   = 1'b0;
      bus.start = 1'b0;
      bus.op    = 4'd0;
      bus.A     = 32'd0;
      bus.B     = 32'd0;

      #3;
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_hi", bus.HI, 32'd0);
      chk("reset_lo", bus.LO, 32'd0);
      chk("reset_occupied", {31'd0, bus.occupied}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // MTHI while idle: zero latency, no busy.
      issue(OpMthi, 32'h0000_00AB, 32'd0);
      @(negedge clk);
      chk("mthi_hi", bus.HI, 32'h0000_00AB);
      chk("mthi_busy", {31'd0, bus.busy}, 32'd0);

      // Reserved op: occupied follows start combinationally, no state change.
      drive(OpRsvd, 32'h1234_5678, 32'd0);
      #1;
      chk("occupied_on_start", {31'd0, bus.occupied}, 32'd1);
      release_start();
      @(negedge clk);
      chk("rsvd_hi", bus.HI, 32'h0000_00AB);
      chk("rsvd_lo", bus.LO, 32'd0);
      chk("rsvd_busy", {31'd0, bus.busy}, 32'd0);

      push("mult_neg1x2", 32'hFFFF_FFFF, 32'hFFFF_FFFE, MultN);
      issue(OpMult, 32'hFFFF_FFFF, 32'd2);
      wait_idle("mult");

      push("multu_max_x2", 32'h0000_0001, 32'hFFFF_FFFE, MultN);
      issue(OpMultu, 32'hFFFF_FFFF, 32'd2);
      wait_idle("multu");

      push("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, DivN);
      issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
      wait_idle("div");

      push("divu_7_2", 32'h0000_0001, 32'h0000_0003, DivN);
      issue(OpDivu, 32'd7, 32'd2);
      wait_idle("divu");

      push("div_overflow", 32'h0000_0000, 32'h8000_0000, DivN);
      issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle("div_ovf");

      // Divide by zero keeps the previous HI/LO.
      issue(OpMthi, 32'h0000_0011, 32'd0);
      issue(OpMtlo, 32'h0000_0022, 32'd0);
      push("div_by_zero", 32'h0000_0011, 32'h0000_0022, DivN);
      issue(OpDiv, 32'd5, 32'd0);
      wait_idle("div0");

      // MTLO while a DIV is in flight is dropped; 100/7 = 14 r 2.
      push("div_100_7", 32'h0000_0002, 32'h0000_000E, DivN);
      issue(OpDiv, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op    = OpMtlo;
      bus.A     = 32'h0000_0055;
      release_start();
      wait_idle("div_mtlo");
      chk("mtlo_while_busy_lo", bus.LO, 32'h0000_000E);

      // Start sampled at the very edge where busy falls must be ignored.
      push("mult_3x5", 32'h0000_0000, 32'h0000_000F, MultN);
      issue(OpMult, 32'd3, 32'd5);
      repeat (MultN - 1) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op    = OpMtlo;
      bus.A     = 32'h0000_0077;
      release_start();
      @(negedge clk);
      chk("b2b_edge_busy", {31'd0, bus.busy}, 32'd0);
      chk("b2b_edge_lo", bus.LO, 32'h0000_000F);
      // One cycle later the same request is accepted.
      issue(OpMtlo, 32'h0000_0077, 32'd0);
      @(negedge clk);
      chk("b2b_next_lo", bus.LO, 32'h0000_0077);

      // Asynchronous reset in the middle of a MULT discards it.
      issue(OpMtlo, 32'h0000_0099, 32'd0);
      @(negedge clk);
      chk("pre_reset_lo", bus.LO, 32'h0000_0099);
      issue(OpMult, 32'd3, 32'd4);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
      chk("midreset_hi", bus.HI, 32'd0);
      chk("midreset_lo", bus.LO, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_reset_hi", bus.HI, 32'd0);
      chk("post_reset_lo", bus.LO, 32'd0);

      // MADDU 1x1 onto HI=0, LO=0xFFFFFFFF.
      issue(OpMthi, 32'd0, 32'd0);
      issue(OpMtlo, 32'hFFFF_FFFF, 32'd0);
`ifdef MDU_MADD_EN
      push("maddu_carry", 32'h0000_0001, 32'h0000_0000, MultN);
      issue(OpMaddu, 32'd1, 32'd1);
      wait_idle("maddu");
`else
      issue(OpMaddu, 32'd1, 32'd1);
      saw_busy = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.busy) saw_busy = 1'b1;
      end
      chk("maddu_noop_busy", {31'd0, saw_busy}, 32'd0);
      chk("maddu_noop_hi", bus.HI, 32'd0);
      chk("maddu_noop_lo", bus.LO, 32'hFFFF_FFFF);
`endif

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits in the E stage beside the ALU and takes operands in the same cycle the E-stage controls are valid. It runs multi-cycle mult/div operations while the E/M pipeline register keeps advancing, and holds HI/LO for mfhi/mflo reads. Busy/occupancy outputs let the hazard unit stall later MDU instructions until the result commits.

## Interface
Parameters
- MULT_CYCLES, 5, busy duration for mult/multu (and madd family when enabled); must be ≥1
- DIV_CYCLES, 10, busy duration for div/divu; must be ≥1

Ports
- clk  in  1  single clock; all state changes on its rising edge
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  E-stage instruction is an MDU op; sampled at the rising edge
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; 10–15 reserved
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- busy  out  1  registered; high while an operation is in flight
- occupied  out  1  combinational; start | busy, consumed by the hazard unit
- HI  out  32  HI register
- LO  out  32  LO register

## Operation
- States: IDLE (busy=0) and RUN (busy=1, down-counter cnt).
- IDLE with start=1 and a multi-cycle op: compute the result from A/B (and from HI/LO for the madd family), latch it into 64-bit pending registers, load cnt with MULT_CYCLES or DIV_CYCLES, and move to RUN.
- IDLE with start=1 and MTHI/MTLO: write A to HI or LO at that edge; busy stays 0.
- RUN: cnt decrements each edge. At the edge where cnt reaches 0, commit pending to {HI,LO}, drop busy, and return to IDLE.
- start while busy=1 is ignored entirely, including MTHI/MTLO. The hazard unit guarantees this does not happen.
- Reserved op codes, or op 6–9 with the macro absent: treated as no-op; no state change.
- MULT: {HI,LO} = signed A × signed B (64 bits). MULTU: unsigned.
- DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. DIVU: unsigned.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero: busy still runs DIV_CYCLES; at commit, HI/LO keep their previous values.
- HI/LO are only observable as committed values; the pending registers are never exposed.

## Timing
- Reset (asynchronous, any time including mid-RUN): busy=0, cnt=0, HI=0, LO=0, pending=0, state IDLE. An in-flight operation is discarded.
- occupied reset value = start (purely combinational).
- With start sampled at edge t0:
  - busy is high for exactly N cycles (edges t0 … t0+N−1 leave it high).
  - busy falls at edge t0+N, and HI/LO take their new values at that same edge.
  - An mfhi/mflo in the cycle after t0+N reads the new value.
- MTHI/MTLO: HI/LO update at t0; zero latency; no busy.
- Back-to-back: a new start sampled at edge t0+N (the edge where busy falls) is ignored, because busy is still 1 at that edge. The earliest accepted start is edge t0+N+1.

## Configuration
- MDU_MADD_EN defined: ops 6–9 are implemented.
  - MADD/MADDU: {HI,LO} += signed/unsigned A×B.
  - MSUB/MSUBU: {HI,LO} −= A×B.
  - The base is the HI/LO value at the start edge; latency is MULT_CYCLES.
- MDU_MADD_EN undefined: ops 6–9 are no-ops, and no accumulate adder is synthesized.

## Test plan
- Reset mid-op: MULT 3×4 started, reset_n pulled low at cycle 2 → busy=0 and HI=LO=0 immediately; no commit afterwards.
- MULT A=0xFFFFFFFF, B=2: busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=1, LO=0xFFFFFFFE.
- DIV A=−7, B=2: 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIV with B=0 after MTHI 0x11 and MTLO 0x22 → HI=0x11, LO=0x22 preserved after 10 cycles.
- MTLO 0x55 asserted while a DIV is busy → ignored; LO holds the quotient after commit. MTHI 0xAB while idle → HI=0xAB at the next edge with busy=0.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU 1×1 → HI=1, LO=0 after 5 cycles. Without the macro, the same op leaves HI/LO unchanged and busy=0.
